// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes; results and flags are registered and held until accepted.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier (opcode 1010); otherwise 1010 is illegal.
module alu_seq #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);
  localparam int SHAMT_W = $clog2(WIDTH);

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_t;
`endif

  state_t             r_state;
  logic [WIDTH-1:0]   r_out;
  logic               r_zero;
  logic               r_carry;
  logic               r_ovf;
  logic               r_illegal;

  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sub;
  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH-1:0]   w_res;
  logic               w_carry;
  logic               w_ovf;
  logic               w_ill;

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_prod;
  logic [SHAMT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   w_prod_next;
  logic               w_is_mul;

  assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : {WIDTH{1'b0}});
`endif

  // SUB is A + ~B + 1 so bit WIDTH is the no-borrow flag.
  assign w_add   = {1'b0, A} + {1'b0, B};
  assign w_sub   = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
  assign w_shamt = B[SHAMT_W-1:0];

  // Single-cycle result and flags from the live operands, used at the accept edge.
  always_comb begin
    w_res   = {WIDTH{1'b0}};
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_ill   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    w_is_mul = 1'b0;
`endif
    case (alu_ctrl)
      4'b0000: begin
        w_res   = w_add[WIDTH-1:0];
        w_carry = w_add[WIDTH];
        w_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (w_add[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0001: begin
        w_res   = w_sub[WIDTH-1:0];
        w_carry = w_sub[WIDTH];
        w_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (w_sub[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0010: w_res = A & B;
      4'b0011: w_res = A | B;
      4'b0100: w_res = A ^ B;
      4'b0101: w_res = A << w_shamt;
      4'b0110: w_res = A >> w_shamt;
      4'b0111: w_res = $signed(A) >>> w_shamt;
      4'b1000: w_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      4'b1001: w_res = {{(WIDTH-1){1'b0}}, (A < B)};
`ifdef ALU_SEQ_MUL_EN
      4'b1010: w_is_mul = 1'b1;
`endif
      default: w_ill = 1'b1;
    endcase
  end

  // Control FSM with registered result, flags and multiplier datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_out     <= {WIDTH{1'b0}};
      r_zero    <= 1'b0;
      r_carry   <= 1'b0;
      r_ovf     <= 1'b0;
      r_illegal <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      r_mcand   <= {WIDTH{1'b0}};
      r_mplier  <= {WIDTH{1'b0}};
      r_prod    <= {WIDTH{1'b0}};
      r_cnt     <= {SHAMT_W{1'b0}};
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
`ifdef ALU_SEQ_MUL_EN
            if (w_is_mul) begin
              r_state  <= S_BUSY;
              r_mcand  <= A;
              r_mplier <= B;
              r_prod   <= {WIDTH{1'b0}};
              r_cnt    <= {SHAMT_W{1'b0}};
            end else
`endif
            begin
              r_state   <= S_DONE;
              r_out     <= w_res;
              r_zero    <= (w_res == {WIDTH{1'b0}});
              r_carry   <= w_carry;
              r_ovf     <= w_ovf;
              r_illegal <= w_ill;
            end
          end
        end
`ifdef ALU_SEQ_MUL_EN
        S_BUSY: begin
          r_prod   <= w_prod_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          if (r_cnt == SHAMT_W'(WIDTH - 1)) begin
            r_state   <= S_DONE;
            r_out     <= w_prod_next;
            r_zero    <= (w_prod_next == {WIDTH{1'b0}});
            r_carry   <= 1'b0;
            r_ovf     <= 1'b0;
            r_illegal <= 1'b0;
          end else begin
            r_cnt <= r_cnt + {{(SHAMT_W-1){1'b0}}, 1'b1};
          end
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out       = r_out;
  assign zero      = r_zero;
  assign carry     = r_carry;
  assign overflow  = r_ovf;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH = 64): directed vectors push expectations, a monitor checks at handshake.
module tb_alu_seq;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] A;
  logic [63:0] B;
  logic [3:0]  alu_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] res;
  logic        zero;
  logic        carry;
  logic        overflow;
  logic        illegal;

  typedef struct {
    logic [63:0] o;
    logic        z;
    logic        c;
    logic        v;
    logic        il;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   first_cyc = 0;
  bit   in_result = 1'b0;

`ifdef ALU_SEQ_MUL_EN
  localparam int MUL_LAT = 65;
`else
  localparam int MUL_LAT = 1;
`endif

  alu_seq #(.WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .alu_ctrl(alu_ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .out(res), .zero(zero), .carry(carry), .overflow(overflow), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  // Monitor: pops and compares on every output handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_result = 1'b0;
    end else begin
      if (out_valid && !in_result) begin
        in_result = 1'b1;
        first_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out", res, e.o);
          chk("flags", {60'd0, zero, carry, overflow, illegal}, {60'd0, e.z, e.c, e.v, e.il});
          chk("latency", 64'(first_cyc - e.acc + 1), 64'(e.lat));
        end
        in_result = 1'b0;
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] eo, input logic ez, input logic ec, input logic ev,
                       input logic ei, input int lat);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      chk("issue_timeout", 64'd1, 64'd0);
      return;
    end
    A = a; B = b; alu_ctrl = op; in_valid = 1'b1;
    @(posedge clk);
    #1;
    e.o = eo; e.z = ez; e.c = ec; e.v = ev; e.il = ei; e.lat = lat; e.acc = cyc;
    sb.push_back(e);
    in_valid = 1'b0;
    A = {$urandom, $urandom};
    B = {$urandom, $urandom};
    alu_ctrl = 4'($urandom);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, {res, 58'd0, out_valid, in_ready, zero, carry, overflow, illegal},
        {64'd0, 58'd0, 1'b0, 1'b1, 4'b0000});
  endtask

  initial begin
    int bad;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = 64'd0; B = 64'd0; alu_ctrl = 4'd0;
    repeat (3) @(posedge clk);
    #2;
    chk_reset_outputs("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    issue(4'b0000, 64'h10, 64'h10, 64'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    issue(4'b0001, 64'h10, 64'h10, 64'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1);
    issue(4'b0010, 64'h10, 64'h10, 64'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    issue(4'b0011, 64'h10, 64'h10, 64'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    issue(4'b0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    issue(4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    issue(4'b1000, 64'hFFFF_FFFF_FFFF_FFF6, 64'd5, 64'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    issue(4'b1001, 64'hFFFF_FFFF_FFFF_FFF6, 64'd5, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    issue(4'b0111, 64'hFFFF_FFFF_FFFF_FFF6, 64'd1, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    issue(4'b0101, 64'hFFFF_FFFF_FFFF_FFF6, 64'h41, 64'hFFFF_FFFF_FFFF_FFEC, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    issue(4'b0100, 64'hF0, 64'hFF, 64'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    issue(4'b0110, 64'h8000_0000_0000_0000, 64'h3F, 64'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    issue(4'b0001, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    issue(4'b0001, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1);
    issue(4'b1111, 64'd7, 64'd9, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1);
    drain();

    // Multiply (or illegal 1010 when the multiplier is not built).
`ifdef ALU_SEQ_MUL_EN
    issue(4'b1010, 64'd3, 64'd5, 64'd15, 1'b0, 1'b0, 1'b0, 1'b0, MUL_LAT);
`else
    issue(4'b1010, 64'd3, 64'd5, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1, MUL_LAT);
`endif
    bad = 0;
    for (int i = 0; i < 100 && !out_valid; i++) begin
      if (in_ready) bad++;
      @(negedge clk);
    end
    chk("mul_in_ready_low", 64'(bad), 64'd0);
    drain();

    // Backpressure: result held, new in_valid ignored.
    out_ready = 1'b0;
    issue(4'b0000, 64'd1, 64'd2, 64'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    A = 64'd9; B = 64'd9; alu_ctrl = 4'b0000; in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!out_valid || in_ready || res !== 64'd3) bad++;
    end
    chk("backpressure_hold", 64'(bad), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("back_to_idle", {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
    chk("backpressure_popped", 64'(sb.size()), 64'd0);

    // Reset while an operation is in flight.
    out_ready = 1'b0;
    issue(4'b1010, 64'd7, 64'd9, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, MUL_LAT);
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("reset_mid_op");
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk("ready_after_reset", {63'd0, in_ready}, 64'd1);
    issue(4'b0000, 64'd1, 64'd1, 64'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    drain();
    issue(4'b1111, 64'd1, 64'd1, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1);
    drain();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
